// File: rtl/stream_mux.sv
// Registered N-input valid/ready stream multiplexer with an external-select or round-robin grant.
// A single output register stage decouples the winning producer from the consumer.
module stream_mux #(
    parameter int NumInp    = 3,
    parameter int DataWidth = 8,
    parameter int IdxWidth  = $clog2(NumInp)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NumInp-1:0]           inp_valid_i,
    output logic [NumInp-1:0]           inp_ready_o,
    input  logic [NumInp*DataWidth-1:0] inp_data_i,
    input  logic                        ext_sel_i,
    input  logic [IdxWidth-1:0]         sel_i,
    output logic                        oup_valid_o,
    input  logic                        oup_ready_i,
    output logic [DataWidth-1:0]        oup_data_o,
    output logic [IdxWidth-1:0]         oup_idx_o
);

    localparam logic EMPTY = 1'b0;
    localparam logic FULL  = 1'b1;

    logic                 state;
    logic [IdxWidth-1:0]  rr_ptr;
    logic                 load_en;
    logic                 gnt_valid;
    logic [IdxWidth-1:0]  gnt_idx;
    logic                 xfer;
    logic [DataWidth-1:0] load_data;
    logic [IdxWidth-1:0]  rr_next;
    int                   cand;

    // Pass-through: a full register that is being drained can take a new beat in the same cycle.
    assign load_en = (state == EMPTY) || oup_ready_i;

    // NOTE: every variable gets a default at the top of the block so no latch is inferred.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        if (ext_sel_i) begin
            if (int'(sel_i) < NumInp && inp_valid_i[sel_i]) begin
                gnt_valid = 1'b1;
                gnt_idx   = sel_i;
            end
        end else begin
            for (int i = 0; i < NumInp; i++) begin
                cand = int'(rr_ptr) + i;
                if (cand >= NumInp) cand = cand - NumInp;
                if (!gnt_valid && inp_valid_i[cand]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = IdxWidth'(cand);
                end
            end
        end
    end

    assign xfer      = load_en && gnt_valid;
    assign load_data = inp_data_i[int'(gnt_idx)*DataWidth +: DataWidth];
    assign rr_next   = (gnt_idx == IdxWidth'(NumInp - 1)) ? '0 : gnt_idx + IdxWidth'(1);

    // Ready is masked during reset, when the register would otherwise look EMPTY.
    always_comb begin
        inp_ready_o = '0;
        if (rst_ni && xfer) inp_ready_o[gnt_idx] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= EMPTY;
            rr_ptr     <= '0;
            oup_data_o <= '0;
            oup_idx_o  <= '0;
        end else if (xfer) begin
            state      <= FULL;
            oup_data_o <= load_data;
            oup_idx_o  <= gnt_idx;
            if (!ext_sel_i) rr_ptr <= rr_next;
        end else if (state == FULL && oup_ready_i) begin
            state <= EMPTY;
        end
    end

    assign oup_valid_o = (state == FULL);

endmodule

// File: tb/tb_stream_mux.sv
// Self-checking bench for stream_mux: directed grant checks plus a scoreboard of expected output beats.
module tb_stream_mux;

    typedef struct packed {
        logic [1:0] idx;
        logic [7:0] data;
    } beat_t;

    logic        clk;
    logic        rst_n;
    logic [2:0]  inp_valid;
    logic [2:0]  inp_ready;
    logic [23:0] inp_data;
    logic        ext_sel;
    logic [1:0]  sel;
    logic        oup_valid;
    logic        oup_ready;
    logic [7:0]  oup_data;
    logic [1:0]  oup_idx;

    logic [7:0]  ch_data [3];
    beat_t       sb_q [$];
    int          total = 0;
    int          bad   = 0;

    assign inp_data = {ch_data[2], ch_data[1], ch_data[0]};

    stream_mux #(.NumInp(3), .DataWidth(8)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .inp_valid_i (inp_valid),
        .inp_ready_o (inp_ready),
        .inp_data_i  (inp_data),
        .ext_sel_i   (ext_sel),
        .sel_i       (sel),
        .oup_valid_o (oup_valid),
        .oup_ready_i (oup_ready),
        .oup_data_o  (oup_data),
        .oup_idx_o   (oup_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Consumer side: a beat leaves the register whenever valid and ready coincide.
    always @(negedge clk) begin
        if (rst_n && oup_valid === 1'b1 && oup_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_beat", 32'(1), 32'(0));
            end else begin
                beat_t e;
                e = sb_q.pop_front();
                check("beat_idx", 32'(oup_idx), 32'(e.idx));
                check("beat_data", 32'(oup_data), 32'(e.data));
            end
        end
    end

    // Drive one cycle of stimulus, check the combinational ready, record the expected beat, then clock.
    task automatic beat(input logic [2:0] v, input logic ext, input logic [1:0] s,
                        input logic ordy, input logic [2:0] exp_rdy);
        beat_t e;
        inp_valid = v;
        ext_sel   = ext;
        sel       = s;
        oup_ready = ordy;
        #1;
        check("inp_ready", 32'(inp_ready), 32'(exp_rdy));
        for (int i = 0; i < 3; i++) begin
            if (exp_rdy[i]) begin
                e.idx  = 2'(i);
                e.data = ch_data[i];
                sb_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        ch_data[0] = 8'h11;
        ch_data[1] = 8'h22;
        ch_data[2] = 8'h33;
        rst_n     = 1'b0;
        inp_valid = 3'b111;
        ext_sel   = 1'b0;
        sel       = 2'd0;
        oup_ready = 1'b1;

        // Reset held with all inputs valid
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_valid", 32'(oup_valid), 32'(0));
        check("rst_data", 32'(oup_data), 32'(0));
        check("rst_idx", 32'(oup_idx), 32'(0));
        check("rst_ready", 32'(inp_ready), 32'(0));
        rst_n = 1'b1;
        beat(3'b111, 1'b0, 2'd0, 1'b1, 3'b001);

        // External select, then an out-of-range select
        beat(3'b111, 1'b1, 2'd2, 1'b1, 3'b100);
        check("ext_data", 32'(oup_data), 32'h33);
        check("ext_idx", 32'(oup_idx), 32'(2));
        beat(3'b111, 1'b1, 2'd3, 1'b1, 3'b000);
        check("ext_oor_valid", 32'(oup_valid), 32'(0));
        check("ext_oor_hold_data", 32'(oup_data), 32'h33);
        check("ext_oor_hold_idx", 32'(oup_idx), 32'(2));

        // Pointer sits at 1: lone channel 2 wins and the pointer wraps to 0
        beat(3'b100, 1'b0, 2'd0, 1'b1, 3'b100);

        // Round-robin fairness, one beat per cycle
        for (int r = 0; r < 2; r++) begin
            beat(3'b111, 1'b0, 2'd0, 1'b1, 3'b001);
            check("rr_full_valid", 32'(oup_valid), 32'(1));
            beat(3'b111, 1'b0, 2'd0, 1'b1, 3'b010);
            check("rr_full_valid", 32'(oup_valid), 32'(1));
            beat(3'b111, 1'b0, 2'd0, 1'b1, 3'b100);
            check("rr_full_valid", 32'(oup_valid), 32'(1));
        end

        // Skip and wrap with channels 0 and 2 only
        beat(3'b101, 1'b0, 2'd0, 1'b1, 3'b001);
        beat(3'b101, 1'b0, 2'd0, 1'b1, 3'b100);
        beat(3'b101, 1'b0, 2'd0, 1'b1, 3'b001);
        beat(3'b101, 1'b0, 2'd0, 1'b1, 3'b100);
        beat(3'b000, 1'b0, 2'd0, 1'b1, 3'b000);
        check("drained", 32'(oup_valid), 32'(0));

        // Backpressure: register full, consumer stalled for four cycles
        ch_data[1] = 8'hA5;
        beat(3'b001, 1'b0, 2'd0, 1'b0, 3'b001);
        for (int c = 0; c < 4; c++) begin
            beat(3'b010, 1'b0, 2'd0, 1'b0, 3'b000);
            check("bp_valid", 32'(oup_valid), 32'(1));
            check("bp_data", 32'(oup_data), 32'h11);
            check("bp_idx", 32'(oup_idx), 32'(0));
        end
        beat(3'b010, 1'b0, 2'd0, 1'b1, 3'b010);
        check("bp_release_valid", 32'(oup_valid), 32'(1));
        check("bp_release_data", 32'(oup_data), 32'hA5);
        check("bp_release_idx", 32'(oup_idx), 32'(1));

        // Reset mid-stream while holding 0x5A
        ch_data[0] = 8'h5A;
        beat(3'b000, 1'b0, 2'd0, 1'b1, 3'b000);
        beat(3'b001, 1'b0, 2'd0, 1'b0, 3'b001);
        check("pre_rst_data", 32'(oup_data), 32'h5A);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(oup_valid), 32'(0));
        check("mid_rst_data", 32'(oup_data), 32'(0));
        check("mid_rst_ready", 32'(inp_ready), 32'(0));
        void'(sb_q.pop_back());
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        beat(3'b111, 1'b0, 2'd0, 1'b1, 3'b001);
        beat(3'b111, 1'b0, 2'd0, 1'b1, 3'b010);
        beat(3'b000, 1'b0, 2'd0, 1'b1, 3'b000);
        beat(3'b000, 1'b0, 2'd0, 1'b1, 3'b000);

        check("sb_empty", 32'(sb_q.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
